// File: rtl/mem_access_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : mem_access_ctrl
//  Description : Memory-side access stage. Latches a read or write request
//                from the address/data buses, waits a fixed number of cycles,
//                then accesses an internal word array. Completion is a
//                one-cycle READY pulse, with ERR for an illegal op, an
//                out-of-range address or (optionally) a protected write.
//                BUSY covers the whole access, from the request latch through
//                the READY cycle.
//
//  Ports       : clk      - system clock, rising edge
//                reset    - asynchronous, active-low reset
//                address  - address bus from the address register stage
//                data     - shared tri-state data bus; driven only during the
//                           DONE cycle of a read
//                CS/RD/WR - chip select, read and write request
//                BUSY     - access in progress (request latch .. READY)
//                READY    - one-cycle completion pulse
//                ERR      - one-cycle error flag, coincident with READY
//
//  Option      : `define MEM_ACCESS_CTRL_WPROT_EN write-protects addresses
//                0..WPROT_SIZE-1. A write there leaves the array unchanged and
//                reports ERR.
//
//  Revision    : 1.0 - initial release
// ============================================================================
module mem_access_ctrl #(
    parameter int DATA_WIDTH  = 8,
    parameter int ADDR_WIDTH  = 16,
    parameter int MEM_DEPTH   = 256,
    parameter int WAIT_STATES = 2,
    parameter int WPROT_SIZE  = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [ADDR_WIDTH-1:0] address,
    inout  wire  [DATA_WIDTH-1:0] data,
    input  logic                  CS,
    input  logic                  RD,
    input  logic                  WR,
    output logic                  BUSY,
    output logic                  READY,
    output logic                  ERR
);

    localparam int                c_idx_w     = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
    // One extra bit so that the limits compare unsigned against the full bus.
    localparam logic [ADDR_WIDTH:0] c_depth   = (ADDR_WIDTH+1)'(MEM_DEPTH);
    localparam logic [ADDR_WIDTH:0] c_wprot   = (ADDR_WIDTH+1)'(WPROT_SIZE);
    localparam logic [3:0]        c_wait_init = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;
`ifdef MEM_ACCESS_CTRL_WPROT_EN
    localparam bit                c_wprot_en  = 1'b1;
`else
    localparam bit                c_wprot_en  = 1'b0;
`endif

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_WAIT   = 2'd1,
        S_ACCESS = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    state_t                  r_state;
    logic [ADDR_WIDTH-1:0]   r_addr;
    logic [DATA_WIDTH-1:0]   r_wdata;
    logic [DATA_WIDTH-1:0]   r_rdata;
    logic                    r_is_read;
    logic [3:0]              r_cnt;
    logic                    r_busy;
    logic                    r_ready;
    logic                    r_err;
    logic                    r_drive;
    logic [DATA_WIDTH-1:0]   r_mem [MEM_DEPTH];

    logic                    w_in_range;
    logic                    w_prot;
    logic [c_idx_w-1:0]      w_idx;
    logic                    w_req_ok;
    logic                    w_req_bad;

    assign w_in_range = ({1'b0, r_addr} < c_depth);
    assign w_prot     = c_wprot_en && ({1'b0, r_addr} < c_wprot);
    // Array index is only meaningful once the range check has passed.
    assign w_idx      = r_addr[c_idx_w-1:0];
    assign w_req_ok   = CS & (RD ^ WR);
    assign w_req_bad  = CS & RD & WR;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state   <= S_IDLE;
            r_addr    <= '0;
            r_wdata   <= '0;
            r_rdata   <= '0;
            r_is_read <= 1'b0;
            r_cnt     <= 4'd0;
            r_busy    <= 1'b0;
            r_ready   <= 1'b0;
            r_err     <= 1'b0;
            r_drive   <= 1'b0;
        end else begin
            // Pulse outputs default low; they are raised only on entry to DONE.
            r_ready <= 1'b0;
            r_err   <= 1'b0;
            r_drive <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_req_bad) begin
                        // Illegal op: no access at all, report straight away.
                        r_is_read <= 1'b0;
                        r_busy    <= 1'b1;
                        r_ready   <= 1'b1;
                        r_err     <= 1'b1;
                        r_state   <= S_DONE;
                    end else if (w_req_ok) begin
                        r_addr    <= address;
                        r_is_read <= RD;
                        if (WR) begin
                            r_wdata <= data;
                        end
                        r_busy    <= 1'b1;
                        r_cnt     <= c_wait_init;
                        r_state   <= (WAIT_STATES > 0) ? S_WAIT : S_ACCESS;
                    end
                end
                S_WAIT: begin
                    if (r_cnt == 4'd0) begin
                        r_state <= S_ACCESS;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                S_ACCESS: begin
                    if (!w_in_range) begin
                        r_rdata <= '1;
                        r_err   <= 1'b1;
                    end else if (r_is_read) begin
                        r_rdata <= r_mem[w_idx];
                    end else if (w_prot) begin
                        r_err   <= 1'b1;
                    end
                    r_ready <= 1'b1;
                    r_drive <= r_is_read;
                    r_state <= S_DONE;
                end
                S_DONE: begin
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // Array write port. The array is not reset; an asserted reset forces the
    // state to IDLE, so a write pending in WAIT is never committed.
    always_ff @(posedge clk) begin
        if (r_state == S_ACCESS && !r_is_read && w_in_range && !w_prot) begin
            r_mem[w_idx] <= r_wdata;
        end
    end

    assign data  = r_drive ? r_rdata : 'z;
    assign BUSY  = r_busy;
    assign READY = r_ready;
    assign ERR   = r_err;

endmodule
`default_nettype wire

// File: tb/tb_mem_access_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mem_access_ctrl
//  Description : Self-checking bench for mem_access_ctrl. Each request pushes
//                its expected completion (latency, ERR, read data) onto a
//                scoreboard queue; the entry is popped and compared when READY
//                arrives. The data bus has a weak pull-down, so "not driven"
//                reads as zero; all read values used here are nonzero.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_access_ctrl;

    localparam int DW = 8;
    localparam int AW = 16;
    localparam int WS = 2;

    logic          clk     = 1'b0;
    logic          reset   = 1'b0;
    logic [AW-1:0] address = '0;
    logic          CS      = 1'b0;
    logic          RD      = 1'b0;
    logic          WR      = 1'b0;
    tri0  [DW-1:0] data;
    logic          BUSY;
    logic          READY;
    logic          ERR;

    logic [DW-1:0] bus_val = '0;
    logic          bus_en  = 1'b0;
    assign data = bus_en ? bus_val : 'z;

    always #5 clk = ~clk;

    mem_access_ctrl #(
        .DATA_WIDTH (DW),
        .ADDR_WIDTH (AW),
        .MEM_DEPTH  (256),
        .WAIT_STATES(WS),
        .WPROT_SIZE (16)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .address(address),
        .data   (data),
        .CS     (CS),
        .RD     (RD),
        .WR     (WR),
        .BUSY   (BUSY),
        .READY  (READY),
        .ERR    (ERR)
    );

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        bit            is_read;
        bit            chk_data;
        logic [DW-1:0] rdata;
        bit            err;
        int            lat;
    } exp_t;

    exp_t          sb[$];
    logic [DW-1:0] last_rd;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // One complete transaction. Latency is the number of rising edges from
    // the request edge to the edge that samples READY high.
    task automatic issue(input bit rd, input bit wr, input logic [AW-1:0] a,
                         input logic [DW-1:0] wd, input logic [DW-1:0] exp_rd,
                         input bit exp_err, input bit chk_rd = 1'b1);
        exp_t e;
        exp_t got_e;
        int   lat;
        e.is_read  = rd & ~wr;
        e.chk_data = chk_rd;
        e.rdata    = exp_rd;
        e.err      = exp_err;
        e.lat      = (rd & wr) ? 1 : WS + 2;
        @(negedge clk);
        check("busy_before_req", BUSY, 0);
        address = a;
        CS      = 1'b1;
        RD      = rd;
        WR      = wr;
        bus_val = wd;
        bus_en  = wr;
        sb.push_back(e);
        @(posedge clk);
        #1;
        CS     = 1'b0;
        RD     = 1'b0;
        WR     = 1'b0;
        bus_en = 1'b0;
        lat    = 1;
        forever begin
            @(negedge clk);
            if (READY) break;
            check("busy_in_wait", BUSY, 1);
            check("data_idle_in_wait", data, 0);
            lat++;
            if (lat > 20) break;
        end
        if (!READY) begin
            check("ready_timeout", READY, 1);
            void'(sb.pop_front());
        end else if (sb.size() != 0) begin
            got_e = sb.pop_front();
            check("latency", lat, got_e.lat);
            check("err", ERR, got_e.err);
            check("busy_in_done", BUSY, 1);
            if (got_e.is_read) begin
                if (got_e.chk_data) check("read_data", data, got_e.rdata);
                last_rd = data;
            end else begin
                check("data_idle_done", data, 0);
            end
        end
    endtask

    initial begin
        // Reset held for three cycles.
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_busy", BUSY, 0);
        check("rst_ready", READY, 0);
        check("rst_err", ERR, 0);
        check("rst_data", data, 0);
        reset = 1'b1;
        @(negedge clk);
        check("post_rst_busy", BUSY, 0);
        check("post_rst_ready", READY, 0);

        // Basic write then read.
        issue(0, 1, 16'h0000, 8'h42, 8'h00, 0);
        issue(0, 1, 16'h0020, 8'hA5, 8'h00, 0);
        issue(1, 0, 16'h0020, 8'h00, 8'hA5, 0);

        // Out-of-range write and read; aliasing index 0 must be untouched.
        issue(0, 1, 16'h0100, 8'h3C, 8'h00, 1);
        issue(1, 0, 16'h0100, 8'h00, 8'hFF, 1);
        issue(1, 0, 16'h0000, 8'h00, 8'h42, 0);
        issue(1, 0, 16'hFFFF, 8'h00, 8'hFF, 1);

        // Illegal op: RD and WR together.
        issue(1, 1, 16'h0020, 8'h66, 8'h00, 1);
        issue(1, 0, 16'h0020, 8'h00, 8'hA5, 0);

        // No chip select: nothing happens.
        @(negedge clk);
        address = 16'h0020;
        RD      = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("nocs_busy", BUSY, 0);
            check("nocs_ready", READY, 0);
        end
        RD = 1'b0;

        // Back-to-back write then read.
        issue(0, 1, 16'h0030, 8'h11, 8'h00, 0);
        issue(1, 0, 16'h0030, 8'h00, 8'h11, 0);

        // Reset in the middle of a write's wait states aborts it.
        issue(0, 1, 16'h0040, 8'h5A, 8'h00, 0);
        @(negedge clk);
        address = 16'h0040;
        CS      = 1'b1;
        WR      = 1'b1;
        bus_val = 8'h99;
        bus_en  = 1'b1;
        @(posedge clk);
        #1;
        CS     = 1'b0;
        WR     = 1'b0;
        bus_en = 1'b0;
        @(negedge clk);
        check("abort_busy_before", BUSY, 1);
        reset = 1'b0;
        #1;
        check("abort_busy_async", BUSY, 0);
        repeat (3) @(negedge clk);
        check("abort_ready", READY, 0);
        reset = 1'b1;
        issue(1, 0, 16'h0040, 8'h00, 8'h5A, 0);

`ifdef MEM_ACCESS_CTRL_WPROT_EN
        issue(1, 0, 16'h0005, 8'h00, 8'h00, 0, 1'b0);
        issue(0, 1, 16'h0005, 8'h77, 8'h00, 1);
        issue(1, 0, 16'h0005, 8'h00, last_rd, 0);
        issue(0, 1, 16'h0010, 8'h77, 8'h00, 0);
        issue(1, 0, 16'h0010, 8'h00, 8'h77, 0);
`else
        issue(0, 1, 16'h0005, 8'h77, 8'h00, 0);
        issue(1, 0, 16'h0005, 8'h00, 8'h77, 0);
        issue(0, 1, 16'h0010, 8'h77, 8'h00, 0);
        issue(1, 0, 16'h0010, 8'h00, 8'h77, 0);
`endif

        check("sb_empty", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
